pipelined_adder: RTL and testbench

Parametrised, pipelined two-operand adder/subtractor with valid/ready handshake on both sides. It is the successor to the team's fixed 8-bit ripple adder and adds configurable width, configurable pipeline depth, a subtract mode, a signed-overflow flag and back-pressure. It is used in datapaths where a WIDTH-bit ripple chain would not close timing in a single cycle.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_segment.sv | 27 ++
 rtl/pipelined_adder.sv | 142 ++++++++++++++
 tb/tb_pipelined_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared types and defaults for the pipelined adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } adder_op_e;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STAGES = 4;

   function automatic int seg_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adder_segment.sv
`default_nettype none
// ============================================================================
// Module   : adder_segment
// Purpose  : One SEG-bit carry-chain slice; also reports the carry into its MSB.
// Revision : 1.0 - initial release
// ============================================================================
module adder_segment #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] i_seg_a,
   input  logic [SEG-1:0] i_seg_b,
   input  logic           i_carry,
   output logic [SEG-1:0] o_seg_sum,
   output logic           o_carry,
   output logic           o_carry_msb
);

   logic [SEG:0] w_total;

   assign w_total   = {1'b0, i_seg_a} + {1'b0, i_seg_b} + {{SEG{1'b0}}, i_carry};
   assign o_seg_sum = w_total[SEG-1:0];
   assign o_carry   = w_total[SEG];
   // The sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out of it.
   assign o_carry_msb = i_seg_a[SEG-1] ^ i_seg_b[SEG-1] ^ w_total[SEG-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Purpose  : Segmented, pipelined adder/subtractor with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int c_seg = seg_width(WIDTH, STAGES);

   if ((WIDTH < 2) || (STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
      $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
   end

   logic             w_advance;
   adder_op_e        w_op;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_c_eff;

   logic [WIDTH-1:0] w_opa_q   [STAGES];
   logic [WIDTH-1:0] w_opb_q   [STAGES];
   logic [WIDTH-1:0] w_sum_q   [STAGES];
   logic             w_carry_q [STAGES];
   logic             w_vld_q   [STAGES];
   logic [c_seg-1:0] w_seg_sum [STAGES];
   logic             w_seg_co  [STAGES];
   logic             w_seg_cm  [STAGES];

   logic             r_ovf;

   // Global stall: everything moves together or nothing moves.
   assign w_advance = !out_valid || out_ready;
   assign in_ready  = w_advance;

   // Subtraction is folded in once at the entry so later stages never see op.
   assign w_op    = adder_op_e'(op);
   assign w_b_eff = (w_op == OP_SUB) ? ~b : b;
   assign w_c_eff = (w_op == OP_SUB) ? ~carry_in : carry_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] w_opa_d;
      logic [WIDTH-1:0] w_opb_d;
      logic [WIDTH-1:0] w_sum_prev;
      logic [WIDTH-1:0] w_sum_d;
      logic             w_cin;
      logic             w_vld_d;

      logic [WIDTH-1:0] r_opa;
      logic [WIDTH-1:0] r_opb;
      logic [WIDTH-1:0] r_sum;
      logic             r_carry;
      logic             r_vld;

      if (k == 0) begin : g_head
         assign w_opa_d    = a;
         assign w_opb_d    = w_b_eff;
         assign w_sum_prev = '0;
         assign w_cin      = w_c_eff;
         assign w_vld_d    = in_valid;
      end else begin : g_body
         assign w_opa_d    = w_opa_q[k-1];
         assign w_opb_d    = w_opb_q[k-1];
         assign w_sum_prev = w_sum_q[k-1];
         assign w_cin      = w_carry_q[k-1];
         assign w_vld_d    = w_vld_q[k-1];
      end

      adder_segment #(
         .SEG (c_seg)
      ) u_seg (
         .i_seg_a     (w_opa_d[k*c_seg +: c_seg]),
         .i_seg_b     (w_opb_d[k*c_seg +: c_seg]),
         .i_carry     (w_cin),
         .o_seg_sum   (w_seg_sum[k]),
         .o_carry     (w_seg_co[k]),
         .o_carry_msb (w_seg_cm[k])
      );

      // Completed low segments ride along; this stage fills in its own slice.
      always_comb begin
         w_sum_d                    = w_sum_prev;
         w_sum_d[k*c_seg +: c_seg]  = w_seg_sum[k];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_vld   <= 1'b0;
         end else if (w_advance) begin
            r_opa   <= w_opa_d;
            r_opb   <= w_opb_d;
            r_sum   <= w_sum_d;
            r_carry <= w_seg_co[k];
            r_vld   <= w_vld_d;
         end
      end

      assign w_opa_q[k]   = r_opa;
      assign w_opb_q[k]   = r_opb;
      assign w_sum_q[k]   = r_sum;
      assign w_carry_q[k] = r_carry;
      assign w_vld_q[k]   = r_vld;
   end

   // Only the top segment sees bit WIDTH-1, so overflow is captured alongside it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_advance) begin
         r_ovf <= w_seg_cm[STAGES-1] ^ w_seg_co[STAGES-1];
      end
   end

   assign out_valid = w_vld_q[STAGES-1];
   assign sum       = w_sum_q[STAGES-1];
   assign carry_out = w_carry_q[STAGES-1];
   assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_adder
// Purpose  : Directed self-checking bench for pipelined_adder (WIDTH 32, STAGES 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;
   import adder_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        carry_in;
   logic        op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        carry_out;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   pipelined_adder #(
      .WIDTH  (32),
      .STAGES (4)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: {overflow, carry_out, sum} from operand signs and a 33-bit add.
   function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                            input logic c, input logic o);
      logic [31:0] yy;
      logic        cc;
      logic [32:0] s;
      yy = o ? ~y : y;
      cc = o ? ~c : c;
      s  = {1'b0, x} + {1'b0, yy} + {32'b0, cc};
      return {(x[31] == yy[31]) && (s[31] != x[31]), s[32], s[31:0]};
   endfunction

   task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic vc, input logic vop, input logic [31:0] es,
                          input logic eco, input logic eov);
      a        = va;
      b        = vb;
      carry_in = vc;
      op       = vop;
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, in_ready, 1);
      step();
      in_valid = 1'b0;
      a        = 32'hDEAD_BEEF;
      b        = 32'h1234_5678;
      repeat (2) step();
      chk({tag, "_early"}, out_valid, 0);
      step();
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, carry_out, eco);
      chk({tag, "_ovf"}, overflow, eov);
      step();
   endtask

   logic [31:0] bp_a  [8] = '{32'h1234_5678, 32'hFFFF_0000, 32'h8000_0000, 32'h0000_00FF,
                              32'h7FFF_FFFF, 32'hAAAA_AAAA, 32'h0000_0000, 32'hFEDC_BA98};
   logic [31:0] bp_b  [8] = '{32'h1111_1111, 32'h0001_0000, 32'h8000_0000, 32'h0000_0001,
                              32'hFFFF_FFFF, 32'h5555_5555, 32'h0000_0001, 32'h0123_4567};
   logic        bp_c  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic        bp_op [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      logic [33:0] exp_v;
      int          sent;
      int          recv;
      bit          exp_vld;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      carry_in  = 1'b0;
      op        = OP_ADD;
      repeat (2) step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", carry_out, 0);
      chk("rst_ovf", overflow, 0);
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      step();

      run_vec("carry_all", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, OP_ADD, 32'h0000_0000, 1'b1, 1'b0);
      run_vec("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h8000_0000, 1'b0, 1'b1);
      run_vec("sub_5_7", 32'd5, 32'd7, 1'b0, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_vec("sub_7_5_b", 32'd7, 32'd5, 1'b1, OP_SUB, 32'h0000_0001, 1'b1, 1'b0);
      run_vec("sub_neg_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1);
      run_vec("seg_ripple", 32'h0000_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h0001_0000, 1'b0, 1'b0);

      // Back-pressure: 8 back-to-back beats, consumer stalls in cycles 5..7.
      sent = 0;
      recv = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         out_ready = !(cyc >= 5 && cyc <= 7);
         in_valid  = (sent < 8);
         if (sent < 8) begin
            a        = bp_a[sent];
            b        = bp_b[sent];
            carry_in = bp_c[sent];
            op       = bp_op[sent];
         end
         #1;
         if (out_valid && recv < 8) begin
            exp_v = ref_add(bp_a[recv], bp_b[recv], bp_c[recv], bp_op[recv]);
            chk($sformatf("bp_sum%0d_c%0d", recv, cyc), sum, exp_v[31:0]);
            chk($sformatf("bp_cout%0d_c%0d", recv, cyc), carry_out, exp_v[32]);
            chk($sformatf("bp_ovf%0d_c%0d", recv, cyc), overflow, exp_v[33]);
            if (!out_ready) chk($sformatf("bp_stall_ready_c%0d", cyc), in_ready, 0);
            else recv++;
         end
         if (in_valid && in_ready) sent++;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_recv_count", recv, 8);
      chk("bp_sent_count", sent, 8);

      // Bubbles: alternating valid pattern must reappear four cycles later.
      for (int cyc = 0; cyc < 12; cyc++) begin
         in_valid = (cyc < 8) && (cyc % 2 == 0);
         a        = cyc;
         b        = 32'h100;
         carry_in = 1'b0;
         op       = OP_ADD;
         exp_vld  = (cyc >= 4) && ((cyc - 4) % 2 == 0);
         chk($sformatf("bubble_vld_c%0d", cyc), out_valid, exp_vld);
         if (exp_vld) chk($sformatf("bubble_sum_c%0d", cyc), sum, 32'h100 + cyc - 4);
         step();
      end
      in_valid = 1'b0;
      step();

      // Reset with three beats in flight.
      for (int i = 0; i < 3; i++) begin
         a        = 32'h0101_0101 * (i + 1);
         b        = 32'h1000_0000;
         carry_in = 1'b1;
         op       = OP_ADD;
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sum", sum, 0);
      chk("midrst_cout", carry_out, 0);
      chk("midrst_ovf", overflow, 0);
      step();
      step();
      rst = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         chk($sformatf("post_rst_idle_c%0d", cyc), out_valid, 0);
         step();
      end
      run_vec("post_rst", 32'h0000_0010, 32'h0000_0003, 1'b0, OP_SUB, 32'h0000_000D, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
